// File: rtl/w5300_udp_tx_seq.sv
// Sequences W5300 register writes that send one UDP datagram on a fixed socket:
// destination fields, payload into TX_FIFOR, write size, then the SEND/SEND_MAC command.
module w5300_udp_tx_seq #(
  parameter int SOCKET  = 0,
  parameter int MAX_LEN = 1472,
  parameter bit USE_MAC = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  input  logic [47:0] dst_mac,
  input  logic [10:0] len,
  input  logic [15:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_rd,
  output logic [9:0]  op_addr,
  output logic [15:0] op_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {IDLE, DMAC, DIP, DPORT, PAYLOAD, WRSR, CMD, FIN} state_t;

  localparam logic [9:0]  OFS    = 10'(SOCKET * 64);
  localparam logic [10:0] MAX_L  = 11'(MAX_LEN);
  localparam logic [15:0] CR_CMD = USE_MAC ? 16'h0021 : 16'h0020;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  words_q, words_d;
  logic [31:0] ip_q;
  logic [15:0] port_q;
  logic [47:0] mac_q;
  logic [10:0] len_q;
  logic        err_q, err_d;
  logic        lat, ld, load_ok, len_ok;
  logic [9:0]  ld_addr;
  logic [15:0] ld_wdata;
  logic [11:0] len_p1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // op_* fields stay frozen while op_valid=1 and op_ready=0; the op register may
  // reload in the same cycle it is accepted, so op_ready held high gives one op per cycle.
  assign load_ok   = !op_valid || op_ready;
  assign len_ok    = (len != 11'd0) && (len <= MAX_L);
  assign len_p1    = {1'b0, len} + 12'd1;
  assign busy      = (state_q != IDLE) && (state_q != FIN);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign op_rd     = 1'b0;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    words_d  = words_q;
    lat      = 1'b0;
    err_d    = 1'b0;
    ld       = 1'b0;
    ld_addr  = 10'd0;
    ld_wdata = 16'd0;
    pl_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            lat     = 1'b1;
            idx_d   = 2'd0;
            words_d = len_p1[10:1];
            state_d = USE_MAC ? DMAC : DIP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DMAC: begin
        if (load_ok) begin
          ld = 1'b1;
          case (idx_q)
            2'd0:    begin ld_addr = 10'h20C + OFS; ld_wdata = mac_q[47:32]; end
            2'd1:    begin ld_addr = 10'h20E + OFS; ld_wdata = mac_q[31:16]; end
            default: begin ld_addr = 10'h210 + OFS; ld_wdata = mac_q[15:0];  end
          endcase
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = DIP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      DIP: begin
        if (load_ok) begin
          ld = 1'b1;
          if (idx_q == 2'd0) begin
            ld_addr  = 10'h214 + OFS;
            ld_wdata = ip_q[31:16];
            idx_d    = 2'd1;
          end else begin
            ld_addr  = 10'h216 + OFS;
            ld_wdata = ip_q[15:0];
            idx_d    = 2'd0;
            state_d  = DPORT;
          end
        end
      end
      DPORT: begin
        if (load_ok) begin
          ld       = 1'b1;
          ld_addr  = 10'h212 + OFS;
          ld_wdata = port_q;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        pl_ready = (words_q != 10'd0) && load_ok;
        if (pl_ready && pl_valid) begin
          ld       = 1'b1;
          ld_addr  = 10'h22E + OFS;
          ld_wdata = pl_data;
          words_d  = words_q - 10'd1;
          if (words_q == 10'd1) begin
            idx_d   = 2'd0;
            state_d = WRSR;
          end
        end
      end
      WRSR: begin
        if (load_ok) begin
          ld = 1'b1;
          if (idx_q == 2'd0) begin
            ld_addr  = 10'h220 + OFS;
            ld_wdata = 16'h0000;
            idx_d    = 2'd1;
          end else begin
            ld_addr  = 10'h222 + OFS;
            ld_wdata = {5'b0, len_q};
            idx_d    = 2'd0;
            state_d  = CMD;
          end
        end
      end
      CMD: begin
        // idx 0: load the command op; idx 1: wait for the bus engine to take it
        if (idx_q == 2'd0) begin
          if (load_ok) begin
            ld       = 1'b1;
            ld_addr  = 10'h202 + OFS;
            ld_wdata = CR_CMD;
            idx_d    = 2'd1;
          end
        end else if (op_ready) begin
          idx_d   = 2'd0;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      words_q  <= 10'd0;
      err_q    <= 1'b0;
      ip_q     <= 32'd0;
      port_q   <= 16'd0;
      mac_q    <= 48'd0;
      len_q    <= 11'd0;
      op_valid <= 1'b0;
      op_addr  <= 10'd0;
      op_wdata <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      err_q   <= err_d;
      if (lat) begin
        ip_q   <= dst_ip;
        port_q <= dst_port;
        mac_q  <= dst_mac;
        len_q  <= len;
      end
      if (ld) begin
        op_valid <= 1'b1;
        op_addr  <= ld_addr;
        op_wdata <= ld_wdata;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_w5300_udp_tx_seq.sv
// Bench for w5300_udp_tx_seq: socket 0 / SEND and socket 3 / SEND_MAC instances,
// op stream checked against a model-filled expected queue.
module tb_w5300_udp_tx_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dst_ip = '0;
  logic [15:0] dst_port = '0;
  logic [47:0] dst_mac = '0;
  logic [10:0] len = '0;
  logic [15:0] pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        op_ready = 1'b0;

  logic        pl_ready0, op_valid0, op_rd0, busy0, done0, err0;
  logic        pl_ready1, op_valid1, op_rd1, busy1, done1, err1;
  logic [9:0]  op_addr0, op_addr1;
  logic [15:0] op_wdata0, op_wdata1;
  logic [2:0]  state_dbg0, state_dbg1;

  logic        pl_ready_m, op_valid_m, op_rd_m, busy_m, done_m, err_m;
  logic [9:0]  op_addr_m;
  logic [15:0] op_wdata_m;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [25:0] exp_q[$];
  logic [15:0] pw[$];
  logic        hold_v = 1'b0;
  logic [26:0] hold_op = '0;

  always #5 clk = ~clk;

  w5300_udp_tx_seq #(.SOCKET(0), .MAX_LEN(1472), .USE_MAC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .dst_ip(dst_ip), .dst_port(dst_port),
    .dst_mac(dst_mac), .len(len), .pl_data(pl_data), .pl_valid(pl_valid && !sel),
    .pl_ready(pl_ready0), .op_valid(op_valid0), .op_ready(op_ready), .op_rd(op_rd0),
    .op_addr(op_addr0), .op_wdata(op_wdata0), .busy(busy0), .done(done0), .err(err0),
    .state_dbg(state_dbg0)
  );

  w5300_udp_tx_seq #(.SOCKET(3), .MAX_LEN(1472), .USE_MAC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .dst_ip(dst_ip), .dst_port(dst_port),
    .dst_mac(dst_mac), .len(len), .pl_data(pl_data), .pl_valid(pl_valid && sel),
    .pl_ready(pl_ready1), .op_valid(op_valid1), .op_ready(op_ready), .op_rd(op_rd1),
    .op_addr(op_addr1), .op_wdata(op_wdata1), .busy(busy1), .done(done1), .err(err1),
    .state_dbg(state_dbg1)
  );

  assign pl_ready_m = sel ? pl_ready1 : pl_ready0;
  assign op_valid_m = sel ? op_valid1 : op_valid0;
  assign op_rd_m    = sel ? op_rd1    : op_rd0;
  assign op_addr_m  = sel ? op_addr1  : op_addr0;
  assign op_wdata_m = sel ? op_wdata1 : op_wdata0;
  assign busy_m     = sel ? busy1     : busy0;
  assign done_m     = sel ? done1     : done0;
  assign err_m      = sel ? err1      : err0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: ops sampled on the falling edge, popped when valid&ready will transfer.
  always @(negedge clk) begin
    if (hold_v)
      check("hold_stable", {4'd0, op_valid_m, op_rd_m, op_addr_m, op_wdata_m}, {4'd0, 1'b1, hold_op});
    if (op_valid_m && op_ready) begin
      if (exp_q.size() == 0) check("extra_op", {5'd0, op_addr_m, op_wdata_m}, 32'hFFFFFFFF);
      else check("op", {5'd0, op_rd_m, op_addr_m, op_wdata_m}, {6'd0, exp_q.pop_front()});
    end
    hold_v  = op_valid_m && !op_ready;
    hold_op = {op_rd_m, op_addr_m, op_wdata_m};
    if (done_m) begin
      done_cnt++;
      check("busy_at_done", 32'(busy_m), 32'd0);
    end
    if (err_m) err_cnt++;
  end

  task automatic push_model(input bit s, input int l, input logic [31:0] ip,
                            input logic [15:0] port, input logic [47:0] mac);
    logic [9:0] ofs;
    ofs = s ? 10'h0C0 : 10'h000;
    pw.delete();
    for (int i = 0; i < (l + 1) / 2; i++) pw.push_back(16'($urandom));
    if (s) begin
      exp_q.push_back({10'h20C + ofs, mac[47:32]});
      exp_q.push_back({10'h20E + ofs, mac[31:16]});
      exp_q.push_back({10'h210 + ofs, mac[15:0]});
    end
    exp_q.push_back({10'h214 + ofs, ip[31:16]});
    exp_q.push_back({10'h216 + ofs, ip[15:0]});
    exp_q.push_back({10'h212 + ofs, port});
    for (int i = 0; i < pw.size(); i++) exp_q.push_back({10'h22E + ofs, pw[i]});
    exp_q.push_back({10'h220 + ofs, 16'h0000});
    exp_q.push_back({10'h222 + ofs, 16'(l)});
    exp_q.push_back({10'h202 + ofs, s ? 16'h0021 : 16'h0020});
  endtask

  task automatic run_dgram(input bit s, input int l, input logic [31:0] ip,
                           input logic [15:0] port, input logic [47:0] mac, input bit stall);
    int d0, e0, cyc, pidx;
    push_model(s, l, ip, port, mac);
    d0 = done_cnt;
    e0 = err_cnt;
    sel = s; dst_ip = ip; dst_port = port; dst_mac = mac; len = 11'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    pidx = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      op_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      pl_valid = (pidx < pw.size()) && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
      pl_data  = (pidx < pw.size()) ? pw[pidx] : 16'h0;
      // a start while busy with an illegal length must be ignored entirely
      start    = (cyc == 4);
      len      = (cyc == 4) ? 11'd0 : 11'(l);
      dst_ip   = (cyc == 4) ? 32'hFFFF_FFFF : ip;
      @(negedge clk);
      if (cyc == 0) check("busy_on", 32'(busy_m), 32'd1);
      if (pl_valid && pl_ready_m) pidx++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    pl_valid = 1'b0;
    op_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("no_err", 32'(err_cnt - e0), 32'd0);
    check("words_used", 32'(pidx), 32'(pw.size()));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_off", 32'(busy_m), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_bad(input bit s, input int l);
    int e0;
    e0 = err_cnt;
    sel = s; len = 11'(l); start = 1'b1; op_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(err_m), 32'd1);
    check("err_busy", 32'(busy_m), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("err_once", 32'(err_cnt - e0), 32'd1);
    check("err_idle", 32'(sel ? state_dbg1 : state_dbg0), 32'd0);
  endtask

  initial begin
    int pidx, cyc;
    #12;
    check("rst_op_valid", {op_valid0, op_valid1}, 2'b00);
    check("rst_op_rd", {op_rd0, op_rd1}, 2'b00);
    check("rst_op_addr", {op_addr0, op_addr1}, 20'd0);
    check("rst_op_wdata", {op_wdata0, op_wdata1}, 32'd0);
    check("rst_flags", {pl_ready0, busy0, done0, err0, pl_ready1, busy1, done1, err1}, 8'd0);
    check("rst_state", {state_dbg0, state_dbg1}, 6'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dgram(1'b0, 16, 32'hC0A8_0164, 16'h1388, 48'h0, 1'b0);
    run_dgram(1'b1, 5, 32'h0A00_0001, 16'h0050, 48'h0008_DC01_0203, 1'b0);
    run_dgram(1'b1, 1, 32'h0A00_0002, 16'h0051, 48'h0008_DC01_0203, 1'b0);
    run_dgram(1'b0, 7, 32'hC0A8_0164, 16'h1388, 48'h0, 1'b1);
    run_dgram(1'b1, 16, 32'hAC10_0203, 16'hBEEF, 48'h0008_DC01_0203, 1'b1);
    run_dgram(1'b0, 1472, 32'h0102_0304, 16'h0007, 48'h0, 1'b1);
    run_bad(1'b0, 0);
    run_bad(1'b0, 1473);
    run_bad(1'b1, 0);

    // reset in the middle of the payload
    push_model(1'b0, 20, 32'h0B0B_0B0B, 16'h1234, 48'h0);
    sel = 1'b0; dst_ip = 32'h0B0B_0B0B; dst_port = 16'h1234; len = 11'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pidx = 0;
    cyc = 0;
    while (pidx < 3 && cyc < 100) begin
      op_ready = 1'b1;
      pl_valid = 1'b1;
      pl_data  = pw[pidx];
      @(negedge clk);
      if (pl_valid && pl_ready_m) pidx++;
      if (pidx < 3) begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    check("mid_words", 32'(pidx), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_op_valid", 32'(op_valid0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_pl_ready", 32'(pl_ready0), 32'd0);
    check("arst_state", 32'(state_dbg0), 32'd0);
    pl_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_dgram(1'b0, 9, 32'hC0A8_0001, 16'h4000, 48'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
